alu_exec_unit: RTL and testbench

Parametrised execute-stage unit: decodes the RISC-V ALU controls (funct3, funct7 bits, op bit 5, ALUOp) and computes the result in the same block. It covers the full RV32I register/immediate ALU set plus, optionally, the M extension: a one-cycle registered multiplier and an iterative radix-2 divider. It sits in the EX stage of the pipelined core and uses a valid/ready handshake so the hazard unit can stall on multi-cycle divides.

---
 rtl/alu_exec_unit.sv | 181 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage integer unit. Decodes the RISC-V ALU controls and
// computes RV32I ALU results, plus optional M-extension multiply (single
// cycle, registered) and restoring divide (one quotient bit per cycle).
//
// state  | meaning
// IDLE   | ready to accept; single-cycle ops latch their result on accept
// DIV    | iterative divide in progress, counter runs WIDTH down to 1
// DONE   | result just written; out_valid for this one cycle
module alu_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int ENABLE_M = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             funct7b0,
  input  logic             opb5,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;

  logic             accept, is_m, is_div, div_signed, div_zero, div_ovf, div_iter;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sra_res, alu_res, mul_res, div_special, mag_a, mag_b, imm_res;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] step_quo, step_rem, fixed_res;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_DIV);
  assign out_valid = (state_q == S_DONE) && !flush;
  assign result    = result_q;
  assign zero      = (result_q == '0);

  assign accept     = in_valid && in_ready && !flush;
  assign is_m       = (ENABLE_M != 0) && (ALUOp == 2'b10) && opb5 && funct7b0;
  assign is_div     = is_m && funct3[2];
  assign div_signed = !funct3[0];
  assign div_zero   = (srcB == '0);
  assign div_ovf    = div_signed && (srcA == MIN_NEG) && (srcB == '1);
  // Divide-by-zero and signed overflow have fixed answers, so they skip iteration.
  assign div_iter   = is_div && !div_zero && !div_ovf;

  assign shamt   = srcB[SW-1:0];
  assign sra_res = $signed(srcA) >>> shamt;

  // RV32I ALU decode and compute
  always_comb begin
    alu_res = '0;
    case (ALUOp)
      2'b00: alu_res = srcA + srcB;
      2'b01: alu_res = srcA - srcB;
      2'b11: alu_res = srcB;
      default: begin
        case (funct3)
          3'b000:  alu_res = (funct7b5 && opb5) ? srcA - srcB : srcA + srcB;
          3'b001:  alu_res = srcA << shamt;
          3'b010:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
          3'b011:  alu_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
          3'b100:  alu_res = srcA ^ srcB;
          3'b101:  alu_res = funct7b5 ? sra_res : srcA >> shamt;
          3'b110:  alu_res = srcA | srcB;
          default: alu_res = srcA & srcB;
        endcase
      end
    endcase
  end

  // Multiply on 2*WIDTH-bit operands, sign-extended only where the op is signed
  always_comb begin
    ext_a   = {{WIDTH{srcA[WIDTH-1] & (funct3[0] ^ funct3[1])}}, srcA};
    ext_b   = {{WIDTH{srcB[WIDTH-1] & (funct3[1:0] == 2'b01)}}, srcB};
    prod    = ext_a * ext_b;
    mul_res = (funct3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  assign mag_a       = (div_signed && srcA[WIDTH-1]) ? -srcA : srcA;
  assign mag_b       = (div_signed && srcB[WIDTH-1]) ? -srcB : srcB;
  assign div_special = funct3[1] ? (div_zero ? srcA : '0) : (div_zero ? '1 : srcA);
  assign imm_res     = is_m ? (funct3[2] ? div_special : mul_res) : alu_res;

  // One restoring step: dividend bits shift out of quo_q into the partial remainder
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign step_quo  = {quo_q[WIDTH-2:0], !diff[WIDTH]};
  assign step_rem  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign fixed_res = is_rem_q ? (r_neg_q ? -step_rem : step_rem)
                              : (q_neg_q ? -step_quo : step_quo);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (div_iter) begin
            state_d  = S_DIV;
            cnt_d    = CW'(WIDTH);
            quo_d    = mag_a;
            rem_d    = '0;
            dvs_d    = mag_b;
            q_neg_d  = div_signed && (srcA[WIDTH-1] != srcB[WIDTH-1]);
            r_neg_d  = div_signed && srcA[WIDTH-1];
            is_rem_d = funct3[1];
          end else begin
            state_d  = S_DONE;
            result_d = imm_res;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fixed_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors plus randomized ops checked
// against a plain-arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0, funct7b0 = 1'b0, opb5 = 1'b0;
  logic [W-1:0] srcA = '0, srcB = '0;
  logic in_ready, out_valid, zero, busy;
  logic [W-1:0] result;
  logic nm_in_ready, nm_out_valid, nm_zero, nm_busy;
  logic [W-1:0] nm_result;

  int checks = 0, errors = 0;
  bit nm_busy_seen = 1'b0;

  typedef struct packed {
    logic [1:0] op; logic [2:0] f3; logic f7b5; logic f7b0; logic ob5;
    logic [31:0] a; logic [31:0] b; logic [31:0] exp; logic [7:0] lat;
  } vec_t;

  alu_exec_unit #(.WIDTH(W), .ENABLE_M(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5),
    .srcA(srcA), .srcB(srcB), .out_valid(out_valid), .result(result), .zero(zero), .busy(busy));

  alu_exec_unit #(.WIDTH(W), .ENABLE_M(0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5),
    .srcA(srcA), .srcB(srcB), .out_valid(nm_out_valid), .result(nm_result), .zero(nm_zero), .busy(nm_busy));

  always #5 clk = ~clk;

  always @(negedge clk) if (nm_busy === 1'b1) nm_busy_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference model: RISC-V semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [2:0] f3,
      input logic f7b5, input logic f7b0, input logic ob5, input logic [31:0] a, input logic [31:0] b,
      input bit en_m);
    longint sa, sb;
    logic [63:0] p;
    int ia;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b11) return b;
    if (en_m && ob5 && f7b0) begin
      case (f3)
        3'd0: return a * b;
        3'd1: begin p = 64'(sa * sb); return p[63:32]; end
        3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
        3'd4: return (b == 32'd0) ? 32'hFFFFFFFF : 32'(sa / sb);
        3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
        3'd6: return (b == 32'd0) ? a : 32'(sa % sb);
        default: return (b == 32'd0) ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: return (f7b5 && ob5) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7b5 ? 32'(ia >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [2:0] f3, input logic f7b0,
      input logic ob5, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b10 && ob5 && f7b0 && f3[2] && b != 32'd0 &&
        !(!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return W + 1;
    return 1;
  endfunction

  // Drive one op, wait (bounded) for out_valid, then sample one cycle later.
  task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic f7b5_v,
      input logic f7b0_v, input logic ob5_v, input logic [31:0] a, input logic [31:0] b,
      output logic [31:0] res, output int lat, output logic rdy_before,
      output logic ov_after, output logic rdy_after, output logic zero_at);
    @(negedge clk);
    rdy_before = in_ready;
    ALUOp = op; funct3 = f3; funct7b5 = f7b5_v; funct7b0 = f7b0_v; opb5 = ob5_v;
    srcA = a; srcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (out_valid === 1'b1) begin lat = k; break; end
      @(posedge clk); #1;
    end
    res = result;
    zero_at = zero;
    @(posedge clk); #1;
    ov_after = out_valid;
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    logic [31:0] r; int lat; logic rdb, ova, rda, zr;
    do_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, r, lat, rdb, ova, rda, zr);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL reset_pre_add got %h exp %h", r, 32'd5); end
    @(negedge clk); #2 rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu();
    vec_t v[5]; logic [31:0] r; int lat; logic rdb, ova, rda, zr;
    v[0] = '{2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 8'd1};
    v[1] = '{2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 8'd1};
    v[2] = '{2'b10, 3'd3, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd1, 8'd1};
    v[3] = '{2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 8'd1};
    v[4] = '{2'b10, 3'd1, 1'b0, 1'b0, 1'b1, 32'd1, 32'h00000021, 32'd2, 8'd1};
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].op, v[i].f3, v[i].f7b5, v[i].f7b0, v[i].ob5, v[i].a, v[i].b, r, lat, rdb, ova, rda, zr);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL alu_result[%0d] got %h exp %h", i, r, v[i].exp); end
      checks++; if (lat != int'(v[i].lat) || ova !== 1'b0) begin errors++; $display("FAIL alu_timing[%0d] got lat %0d ov_after %b exp lat %0d ov_after 0", i, lat, ova, v[i].lat); end
    end
  endtask

  task automatic test_mul();
    vec_t v[4]; logic [31:0] r; int lat; logic rdb, ova, rda, zr;
    v[0] = '{2'b10, 3'd1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 8'd1};
    v[1] = '{2'b10, 3'd3, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd1};
    v[2] = '{2'b10, 3'd0, 1'b0, 1'b1, 1'b1, 32'h00010000, 32'h00010000, 32'd0, 8'd1};
    v[3] = '{2'b10, 3'd2, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 8'd1};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].op, v[i].f3, v[i].f7b5, v[i].f7b0, v[i].ob5, v[i].a, v[i].b, r, lat, rdb, ova, rda, zr);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL mul_result[%0d] got %h exp %h", i, r, v[i].exp); end
      checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_div();
    vec_t v[7]; logic [31:0] r; int lat; logic rdb, ova, rda, zr;
    v[0] = '{2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 8'd33};
    v[1] = '{2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 8'd33};
    v[2] = '{2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'd100, 32'd0, 32'hFFFFFFFF, 8'd1};
    v[3] = '{2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1};
    v[4] = '{2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 8'd1};
    v[5] = '{2'b10, 3'd7, 1'b0, 1'b1, 1'b1, 32'd100, 32'd0, 32'd100, 8'd1};
    v[6] = '{2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 8'd33};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].op, v[i].f3, v[i].f7b5, v[i].f7b0, v[i].ob5, v[i].a, v[i].b, r, lat, rdb, ova, rda, zr);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL div_result[%0d] got %h exp %h", i, r, v[i].exp); end
      checks++; if (lat != int'(v[i].lat) || rda !== 1'b1) begin errors++; $display("FAIL div_timing[%0d] got lat %0d rdy_after %b exp lat %0d rdy_after 1", i, lat, rda, v[i].lat); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev; bit seen;
    @(negedge clk);
    ALUOp = 2'b10; funct3 = 3'd5; funct7b5 = 1'b0; funct7b0 = 1'b1; opb5 = 1'b1;
    srcA = 32'd1000; srcB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    prev = result;
    seen = (out_valid === 1'b1);
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_c10 got %b exp 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_c11 got %b exp 1", in_ready); end
    checks++; if (seen || out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_out_valid got seen %b ov %b exp 0 0", seen, out_valid); end
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_held got %h exp %h", result, prev); end
    ALUOp = 2'b00; srcA = 32'd2; srcB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL flush_next_add got ov %b res %h exp 1 %h", out_valid, result, 32'd5); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int pulses;
    @(negedge clk);
    ALUOp = 2'b00; srcA = 32'd10; srcB = 32'd20; in_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    in_valid = 1'b0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
    checks++; if (result !== 32'd30) begin errors++; $display("FAIL b2b_result got %h exp %h", result, 32'd30); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    @(negedge clk);
    ALUOp = 2'b10; funct3 = 3'd5; funct7b5 = 1'b0; funct7b0 = 1'b1; opb5 = 1'b1;
    srcA = 32'd1000; srcB = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL middiv_busy got busy %b rdy %b exp 1 0", busy, in_ready); end
    #2 rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL middiv_reset got busy %b rdy %b exp 0 1", busy, in_ready); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen || result !== 32'd0) begin errors++; $display("FAIL middiv_abandon got seen %b res %h exp 0 0", seen, result); end
  endtask

  task automatic test_no_m();
    logic [31:0] r; int lat; logic rdb, ova, rda, zr;
    do_op(2'b10, 3'd0, 1'b0, 1'b1, 1'b1, 32'd40, 32'd2, r, lat, rdb, ova, rda, zr);
    checks++; if (nm_result !== 32'd42) begin errors++; $display("FAIL nom_add got %h exp %h", nm_result, 32'd42); end
    checks++; if (r !== 32'd80) begin errors++; $display("FAIL m_mul_same_ctrl got %h exp %h", r, 32'd80); end
    do_op(2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, r, lat, rdb, ova, rda, zr);
    checks++; if (nm_result !== 32'hFF00FF00) begin errors++; $display("FAIL nom_xor got %h exp %h", nm_result, 32'hFF00FF00); end
    checks++; if (nm_zero !== 1'b0 || nm_in_ready !== 1'b1) begin errors++; $display("FAIL nom_status got zero %b rdy %b exp 0 1", nm_zero, nm_in_ready); end
    checks++; if (nm_busy_seen) begin errors++; $display("FAIL nom_busy got 1 exp 0"); end
  endtask

  task automatic test_random(input int n, input bit m_only);
    logic [1:0] op; logic [2:0] f3; logic f7b5, f7b0, ob5;
    logic [31:0] a, b, exp, r; int el, lat; logic rdb, ova, rda, zr;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3)); f3 = 3'($urandom);
      f7b5 = 1'($urandom); f7b0 = 1'($urandom); ob5 = 1'($urandom);
      if (m_only) begin op = 2'b10; f7b0 = 1'b1; ob5 = 1'b1; end
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(0, 40);
        3: a = $urandom_range(0, 200);
        default: ;
      endcase
      exp = model(op, f3, f7b5, f7b0, ob5, a, b, 1'b1);
      el = exp_lat(op, f3, f7b0, ob5, a, b);
      do_op(op, f3, f7b5, f7b0, ob5, a, b, r, lat, rdb, ova, rda, zr);
      checks++; if (r !== exp) begin errors++; $display("FAIL rand_result op=%0d f3=%0d f7=%b%b opb5=%b a=%h b=%h got %h exp %h", op, f3, f7b5, f7b0, ob5, a, b, r, exp); end
      checks++; if (lat != el) begin errors++; $display("FAIL rand_latency a=%h b=%h got %0d exp %0d", a, b, lat, el); end
      checks++; if (rdb !== 1'b1 || ova !== 1'b0 || rda !== 1'b1) begin errors++; $display("FAIL rand_handshake got rdy_before %b ov_after %b rdy_after %b exp 1 0 1", rdb, ova, rda); end
      checks++; if (zr !== (exp == 32'd0)) begin errors++; $display("FAIL rand_zero got %b exp %b", zr, (exp == 32'd0)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_alu();
    test_mul();
    test_flush();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    test_no_m();
    test_random(40, 1'b0);
    test_random(30, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
